fifo_read_stream: RTL
=====================

# fifo_read_stream

Read-side drain for the async circular FIFO. Lives entirely in the read clock domain and pops words through the FIFO read port (read strobe, empty flag, read data). Presents the words downstream as a valid/ready stream through a 3-entry elastic buffer. Sustains one word per cycle for FIFO read latency 0 or 1, with no combinational path from `m_ready_in` to the FIFO read strobe.

## Interface
- `WIDTH`, 8, data word width; must match the FIFO `WIDTH`.
- `READ_LATENCY`, 0, cycles from an accepted read strobe to valid `fifo_data_in`. Legal values are 0 and 1; any other value is a synthesis error.
- `CNT_WIDTH`, 16, width of the delivered-word counter.

Ports:
- `clk_in` in 1: read-domain clock, same clock as the FIFO read side.
- `rst_in` in 1: reset, synchronous, active-high.
- `fifo_empty_in` in 1: FIFO empty flag.
- `fifo_data_in` in `WIDTH`: FIFO read data.
- `fifo_read_out` out 1: FIFO read strobe; drives FIFO `read_in`.
- `m_data_out` out `WIDTH`: stream data.
- `m_valid_out` out 1: stream valid.
- `m_ready_in` in 1: stream ready from downstream.
- `word_count_out` out `CNT_WIDTH`: count of words delivered downstream.

## Operation
- **Buffer.** 3 entries, circular, with 2-bit `head` and `tail` pointers that wrap 2→0. An occupancy counter `occ` runs 0..3.
- **Reservation counter.** `resv` (0..3) counts buffered words plus reads still in flight.
  - +1 on each issued read.
  - −1 on each stream transfer (`m_valid_out && m_ready_in`).
  - Both in the same cycle: no change.
- **Read issue.** `fifo_read_out = !rst_in && !fifo_empty_in && (resv < 3)`.
  - Never asserted while the FIFO is empty.
  - Never asserted when `resv == 3`, so the buffer cannot overflow.
- **Capture.**
  - The read issued at cycle t is written to `buf[tail]` at the end of cycle t + `READ_LATENCY`.
  - `tail` advances and `occ` increments on that write.
  - For `READ_LATENCY` = 1, a 1-bit registered `rd_pend` marks the capture cycle.
- **Output.**
  - `m_valid_out = (occ != 0)`, driven from a register.
  - `m_data_out = buf[head]`.
  - On transfer, `head` advances and `occ` decrements.
  - Capture and transfer in the same cycle leave `occ` unchanged.
- **Word counter.** `word_count_out` increments on every transfer and wraps from 2^`CNT_WIDTH`−1 to 0.
- **Ordering.** Words leave in exact FIFO pop order. No drop, no duplication.
- **Reset values.** `fifo_read_out`=0, `m_valid_out`=0, `m_data_out`=0, `word_count_out`=0. Internal state `buf[*]`, `head`, `tail`, `occ`, `resv` and `rd_pend` all reset to 0.
- **Reset mid-operation.**
  - Buffered words are discarded.
  - In-flight read data arriving during or after the reset cycle is not captured.
  - The system asserts FIFO `r_nrst_in` together with `rst_in`.

## Timing
- **Latency.** FIFO non-empty and `resv < 3` at cycle t gives a read at t. `m_valid_out` rises at t+1 (`READ_LATENCY` = 0) or t+2 (`READ_LATENCY` = 1).
- **Throughput.** With `m_ready_in` held high and the FIFO non-empty, one transfer per cycle for both latencies. Steady state is `resv` = 1 (latency 0) or 2 (latency 1).
- **Backpressure.**
  - With `m_ready_in` low, the block issues at most 3 reads total, then `fifo_read_out` stays 0.
  - After `m_ready_in` returns high, reads resume in the cycle following the first transfer, since `resv` is a register.
- **Stream rules.**
  - `m_data_out` is stable while `m_valid_out && !m_ready_in`.
  - `m_valid_out` never drops without a transfer.
- **FIFO goes empty mid-burst.** Reads stop the same cycle, and already-issued words still arrive and are delivered.
- **Unused input.** `fifo_data_in` is ignored in cycles that are not capture cycles.

## Test plan
- **Reset.** Hold `rst_in` high 3 cycles with the FIFO non-empty → `fifo_read_out`=0, `m_valid_out`=0, `m_data_out`=0, `word_count_out`=0 throughout.
- **Streaming, both latencies.** FIFO model preloaded with 0x01..0x10, `m_ready_in`=1, run for `READ_LATENCY` 0 and 1 → first `m_valid_out` at cycle 2 / 3 after reset release, 16 consecutive transfers 0x01..0x10 with no gaps, `word_count_out`=16.
- **Backpressure.** Preload 0xA0..0xA7, `m_ready_in`=0 for 10 cycles → exactly 3 `fifo_read_out` pulses, `m_data_out`=0xA0 held stable. Then `m_ready_in`=1 → 0xA0..0xA7 delivered in order, none lost or duplicated.
- **Empty gap.** FIFO provides 2 words, goes empty for 5 cycles, then provides 2 more → `fifo_read_out` is 0 during the gap, `m_valid_out` drops only after the 2nd transfer, all 4 words are delivered in order.
- **Random ready.** Random `m_ready_in` (50%) over 1000 words with a counter pattern, latency 1 → scoreboard match, `fifo_read_out` never high while `fifo_empty_in`=1, `occ` never exceeds 3.
- **Reset mid-burst and counter wrap.**
  - `rst_in` pulsed with `resv`=3 → next cycle all outputs are 0 and no stale word appears after release.
  - `CNT_WIDTH`=4 with 17 transfers → `word_count_out`=1.

Source files
------------

// File: rtl/fifo_read_stream.sv
// rtl/fifo_read_stream.sv - read-side FIFO drain presenting words as a valid/ready stream
//
// Pops words from the async FIFO read port and delivers them downstream through
// a 3-entry elastic buffer, one word per cycle for FIFO read latency 0 or 1.
//
// Parameters:
//   WIDTH          data word width, matches the FIFO word width
//   READ_LATENCY   cycles from accepted read strobe to valid fifo_data_in (0 or 1)
//   CNT_WIDTH      width of the delivered-word counter
//
// Ports:
//   clk_in          read-domain clock
//   rst_in          synchronous active-high reset
//   fifo_empty_in   FIFO empty flag
//   fifo_data_in    FIFO read data
//   fifo_read_out   FIFO read strobe
//   m_data_out      stream data
//   m_valid_out     stream valid
//   m_ready_in      stream ready from downstream
//   word_count_out  number of words delivered downstream (wrapping)

module fifo_read_stream #(
  parameter int WIDTH        = 8,
  parameter int READ_LATENCY = 0,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 fifo_empty_in,
  input  logic [WIDTH-1:0]     fifo_data_in,
  output logic                 fifo_read_out,
  output logic [WIDTH-1:0]     m_data_out,
  output logic                 m_valid_out,
  input  logic                 m_ready_in,
  output logic [CNT_WIDTH-1:0] word_count_out
);

  generate
    if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : g_bad_latency
      $error("fifo_read_stream: READ_LATENCY must be 0 or 1");
    end
  endgenerate

  logic [WIDTH-1:0]     buf_q [3];
  logic [WIDTH-1:0]     buf_d [3];
  logic [1:0]           head_q, head_d;
  logic [1:0]           tail_q, tail_d;
  logic [1:0]           occ_q, occ_d;
  logic [1:0]           resv_q, resv_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 valid_q, valid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic issue;
  logic capture;
  logic transfer;

  // Pointers walk 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    // resv counts buffered words plus reads still in flight, so holding it
    // below 3 guarantees every issued read has a free slot when it lands.
    issue    = !rst_in && !fifo_empty_in && (resv_q != 2'd3);
    transfer = valid_q && m_ready_in;
    // With latency 1 the data for a read lands one cycle later; rd_pend marks it.
    capture  = (READ_LATENCY == 1) ? rd_pend_q : issue;

    buf_d     = buf_q;
    head_d    = head_q;
    tail_d    = tail_q;
    occ_d     = occ_q;
    resv_d    = resv_q;
    cnt_d     = cnt_q;
    rd_pend_d = issue;

    if (capture) begin
      buf_d[tail_q] = fifo_data_in;
      tail_d        = ptr_inc(tail_q);
    end

    if (transfer) begin
      head_d = ptr_inc(head_q);
      cnt_d  = cnt_q + CNT_WIDTH'(1);
    end

    case ({capture, transfer})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    case ({issue, transfer})
      2'b10:   resv_d = resv_q + 2'd1;
      2'b01:   resv_d = resv_q - 2'd1;
      default: resv_d = resv_q;
    endcase

    valid_d = (occ_d != 2'd0);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
      head_q    <= 2'd0;
      tail_q    <= 2'd0;
      occ_q     <= 2'd0;
      resv_q    <= 2'd0;
      rd_pend_q <= 1'b0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      buf_q     <= buf_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      occ_q     <= occ_d;
      resv_q    <= resv_d;
      rd_pend_q <= rd_pend_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign fifo_read_out  = issue;
  assign m_valid_out    = valid_q;
  assign m_data_out     = buf_q[head_q];
  assign word_count_out = cnt_q;

endmodule
